ctrl_74hc165: RTL and testbench

//  Reader for a chain of 74HC165 parallel-in/serial-out shift registers (buttons/DIP switches);

---
 rtl/ctrl_74hc165.sv | 166 ++++++++++++++++
 tb/tb_ctrl_74hc165.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_74hc165.sv
// Scanner for a chain of 74HC165 PISO registers: latches the pins with PL, shifts them out
// MSB-first on CP and publishes each complete frame with valid/changed strobes.
module ctrl_74hc165 #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_q7,
    output logic             o_pl_n,
    output logic             o_cp,
    output logic             o_ce_n,
    output logic [WIDTH-1:0] o_data,
    output logic             o_vld,
    output logic             o_chg
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] LOW  = 3'd2;
    localparam logic [2:0] HIGH = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [DIV_W-1:0] div_cnt_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] sreg_nxt_s;
    logic             q7_meta_r;
    logic             q7_sync_r;
    logic             q7_s;
    logic             phase_end_s;
    logic             bit_last_s;
    logic             frame_end_s;
    logic             pl_n_r;
    logic             cp_r;
    logic             ce_n_r;
    logic [WIDTH-1:0] data_r;
    logic             vld_r;
    logic             chg_r;

    assign q7_s        = q7_sync_r;
    assign phase_end_s = (div_cnt_r == DIV_LAST);
    assign bit_last_s  = (bit_cnt_r == BIT_LAST);
    assign sreg_nxt_s  = {sreg_r[WIDTH-2:0], q7_s};
    // The frame is published on the same edge that captures its last bit.
    assign frame_end_s = (state_r == LOW) && phase_end_s && bit_last_s;

    // Two-flop synchronizer for the asynchronous Q7 pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            q7_meta_r <= 1'b0;
            q7_sync_r <= 1'b0;
        end else begin
            q7_meta_r <= i_q7;
            q7_sync_r <= q7_meta_r;
        end
    end

    // Next-state decode for the scan sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_en) state_nxt_s = LOAD;
                else      state_nxt_s = IDLE;
            end
            LOAD: begin
                if (phase_end_s) state_nxt_s = LOW;
                else             state_nxt_s = LOAD;
            end
            LOW: begin
                if (phase_end_s) begin
                    if (bit_last_s) state_nxt_s = DONE;
                    else            state_nxt_s = HIGH;
                end else begin
                    state_nxt_s = LOW;
                end
            end
            HIGH: begin
                if (phase_end_s) state_nxt_s = LOW;
                else             state_nxt_s = HIGH;
            end
            DONE: begin
                if (i_en) state_nxt_s = LOAD;
                else      state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, phase divider, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            div_cnt_r <= {DIV_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
            sreg_r    <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if ((state_nxt_s != state_r) || (state_r == IDLE)) begin
                div_cnt_r <= {DIV_W{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
            if (state_r == LOAD) begin
                bit_cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == HIGH) && phase_end_s) begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if ((state_r == LOW) && phase_end_s) begin
                sreg_r <= sreg_nxt_s;
            end else begin
                sreg_r <= sreg_r;
            end
        end
    end

    // Pin drivers are decoded from the next state so they change cleanly on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pl_n_r <= 1'b1;
            cp_r   <= 1'b0;
            ce_n_r <= 1'b1;
        end else begin
            pl_n_r <= (state_nxt_s != LOAD);
            cp_r   <= (state_nxt_s == HIGH);
            ce_n_r <= !((state_nxt_s == LOW) || (state_nxt_s == HIGH) || (state_nxt_s == DONE));
        end
    end

    // Published frame and its strobes; o_chg compares against the held word, even across idle gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= {WIDTH{1'b0}};
            vld_r  <= 1'b0;
            chg_r  <= 1'b0;
        end else begin
            vld_r <= frame_end_s;
            chg_r <= frame_end_s && (sreg_nxt_s != data_r);
            if (frame_end_s) begin
                data_r <= sreg_nxt_s;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign o_pl_n = pl_n_r;
    assign o_cp   = cp_r;
    assign o_ce_n = ce_n_r;
    assign o_data = data_r;
    assign o_vld  = vld_r;
    assign o_chg  = chg_r;

endmodule

// File: tb/tb_ctrl_74hc165.sv
// Bench for ctrl_74hc165: two instances (CLK_DIV=4 and CLK_DIV=3) each driven by a 74HC165 chain model;
// expected frames are queued when the chain pattern is set and popped when o_vld fires.
module tb_ctrl_74hc165;

    typedef struct packed {
        logic [15:0] d;
        logic        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic        q7_a, q7_b;
    logic        pl_n_a, cp_a, ce_n_a, vld_a, chg_a;
    logic        pl_n_b, cp_b, ce_n_b, vld_b, chg_b;
    logic [15:0] data_a, data_b;

    logic [15:0] par_a = 16'h0, par_b = 16'h0;
    logic [15:0] chain_a = 16'h0, chain_b = 16'h0;
    logic        cpd_a = 1'b0, cpd_b = 1'b0;
    logic [15:0] last_a = 16'h0, last_b = 16'h0;

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ctrl_74hc165 #(.WIDTH(16), .CLK_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .i_en(en_a), .i_q7(q7_a),
        .o_pl_n(pl_n_a), .o_cp(cp_a), .o_ce_n(ce_n_a),
        .o_data(data_a), .o_vld(vld_a), .o_chg(chg_a)
    );

    ctrl_74hc165 #(.WIDTH(16), .CLK_DIV(3)) dut_b (
        .clk(clk), .rst(rst), .i_en(en_b), .i_q7(q7_b),
        .o_pl_n(pl_n_b), .o_cp(cp_b), .o_ce_n(ce_n_b),
        .o_data(data_b), .o_vld(vld_b), .o_chg(chg_b)
    );

    // Chain models: load while PL is low, shift one clk after a CP rise with CE low.
    always @(posedge clk) begin
        cpd_a <= cp_a;
        cpd_b <= cp_b;
        if (!pl_n_a) chain_a <= par_a;
        else if (cp_a && !cpd_a && !ce_n_a) chain_a <= {chain_a[14:0], 1'b0};
        if (!pl_n_b) chain_b <= par_b;
        else if (cp_b && !cpd_b && !ce_n_b) chain_b <= {chain_b[14:0], 1'b0};
    end

    assign q7_a = chain_a[15];
    assign q7_b = chain_b[15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit sel, input logic [15:0] p);
        exp_t e;
        e.d = p;
        if (sel) begin
            e.c = (p != last_b);
            last_b = p;
            q_b.push_back(e);
        end else begin
            e.c = (p != last_a);
            last_a = p;
            q_a.push_back(e);
        end
    endtask

    // Waits (bounded) for the next o_vld of one instance, measuring PL/CP activity on the way.
    task automatic run_frame(input bit sel, input int drop_at,
                             output int tot, output int lat, output int pl, output int rises);
        exp_t        e;
        logic        got = 1'b0;
        logic        have;
        logic        pcp = 1'b0;
        logic        pl_s, cp_s;
        logic [15:0] d_s = 16'h0;
        logic        c_s = 1'b0;
        int          first = -1;
        tot = 0; pl = 0; rises = 0;
        for (int i = 1; i <= 400 && !got; i++) begin
            @(negedge clk);
            tot = i;
            if (!sel && i == drop_at) en_a = 1'b0;
            pl_s = sel ? pl_n_b : pl_n_a;
            cp_s = sel ? cp_b : cp_a;
            if (!pl_s) begin
                pl++;
                if (first < 0) first = i;
            end
            if (cp_s && !pcp) rises++;
            pcp = cp_s;
            if (sel ? vld_b : vld_a) begin
                got = 1'b1;
                d_s = sel ? data_b : data_a;
                c_s = sel ? chg_b : chg_a;
            end
        end
        lat = (first < 0) ? -1 : tot - first;
        total++;
        assert (got) else begin
            bad++;
            $error("FAIL vld_timeout observed=0 expected=1");
        end
        if (got) begin
            have = sel ? (q_b.size() > 0) : (q_a.size() > 0);
            total++;
            assert (have) else begin
                bad++;
                $error("FAIL sb_empty observed=vld expected=no_vld");
            end
            if (have) begin
                e = sel ? q_b.pop_front() : q_a.pop_front();
                chk(sel ? "b_data" : "a_data", {16'h0, d_s}, {16'h0, e.d});
                chk(sel ? "b_chg" : "a_chg", {31'h0, c_s}, {31'h0, e.c});
            end
        end
    endtask

    initial begin
        int   tot, lat, pl, rises;
        logic seen;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_pl_n", {31'h0, pl_n_a}, 32'h1);
        chk("rst_cp", {31'h0, cp_a}, 32'h0);
        chk("rst_ce_n", {31'h0, ce_n_a}, 32'h1);
        chk("rst_data", {16'h0, data_a}, 32'h0);
        chk("rst_vld", {31'h0, vld_a}, 32'h0);
        chk("rst_chg", {31'h0, chg_a}, 32'h0);

        // 1: first frame 0xA5C3
        par_a = 16'hA5C3;
        push(1'b0, par_a);
        en_a = 1'b1;
        run_frame(1'b0, 0, tot, lat, pl, rises);
        chk("t1_lat", lat, 128);
        chk("t1_pl_cycles", pl, 4);
        chk("t1_cp_rises", rises, 15);

        // 2: same pattern, back-to-back frame period
        push(1'b0, par_a);
        run_frame(1'b0, 0, tot, lat, pl, rises);
        chk("t2_period", tot, 129);
        chk("t2_lat", lat, 128);

        // 3: single-bit patterns check MSB-first ordering
        par_a = 16'h0001;
        push(1'b0, par_a);
        run_frame(1'b0, 0, tot, lat, pl, rises);
        par_a = 16'h8000;
        push(1'b0, par_a);
        run_frame(1'b0, 0, tot, lat, pl, rises);

        // 4: drop i_en while bit 7 is being sampled; frame still completes, then idle
        par_a = 16'h3C0F;
        push(1'b0, par_a);
        run_frame(1'b0, 62, tot, lat, pl, rises);
        chk("t4_lat", lat, 128);
        pl = 0;
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (!pl_n_a) pl++;
            if (vld_a) seen = 1'b1;
        end
        chk("t4_no_pl", pl, 0);
        chk("t4_no_vld", {31'h0, seen}, 32'h0);
        chk("t4_idle_pl_n", {31'h0, pl_n_a}, 32'h1);
        chk("t4_idle_ce_n", {31'h0, ce_n_a}, 32'h1);
        chk("t4_idle_cp", {31'h0, cp_a}, 32'h0);
        chk("t4_hold_data", {16'h0, data_a}, 32'h3C0F);

        // 5: reset during bit 9 aborts the frame; a fresh frame follows
        par_a = 16'h1234;
        en_a = 1'b1;
        seen = 1'b0;
        repeat (78) begin
            @(negedge clk);
            if (vld_a) seen = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (vld_a) seen = 1'b1;
        last_a = 16'h0;
        chk("t5_pl_n", {31'h0, pl_n_a}, 32'h1);
        chk("t5_cp", {31'h0, cp_a}, 32'h0);
        chk("t5_ce_n", {31'h0, ce_n_a}, 32'h1);
        chk("t5_data", {16'h0, data_a}, 32'h0);
        chk("t5_chg", {31'h0, chg_a}, 32'h0);
        chk("t5_no_vld", {31'h0, seen}, 32'h0);
        push(1'b0, par_a);
        run_frame(1'b0, 0, tot, lat, pl, rises);
        chk("t5_lat", lat, 128);
        en_a = 1'b0;

        // 6: CLK_DIV=3, random frames; first frame all-zero must not flag a change
        for (int i = 0; i < 50; i++) begin
            if (i == 0) par_b = 16'h0;
            else if (i % 7 != 3) par_b = 16'($urandom);
            push(1'b1, par_b);
            en_b = 1'b1;
            run_frame(1'b1, 0, tot, lat, pl, rises);
            chk("t6_lat", lat, 96);
            chk("t6_pl_cycles", pl, 3);
            chk("t6_cp_rises", rises, 15);
        end
        en_b = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
